decode_pipe_ctrl: RTL



---
 rtl/decode_pipe_if.sv | 38 +++
 rtl/decode_pipe_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe_if.sv
// ID/EX control handshake bundle for the pipelined decode stage.
// master drives the ID instruction, EX compare flags and resume; slave is the decoder.
interface decode_pipe_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]     id_instr;
  logic                      id_valid;
  logic                      id_ready;
  logic                      ex_eq;
  logic                      ex_lt;
  logic                      ex_ltu;
  logic                      resume;
  logic                      ex_valid;
  logic [3:0]                ex_ALUctrl;
  logic                      ex_ALUsrc;
  logic [2:0]                ex_ImmSrc;
  logic                      ex_RegWrite;
  logic [2:0]                ex_AddrMode;
  logic                      ex_ResultSrc;
  logic                      ex_WD3Src;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic [1:0]                PCsrc;
  logic                      flush;
  logic                      halted;

  modport master (
    output id_instr, id_valid, ex_eq, ex_lt, ex_ltu, resume,
    input  id_ready, ex_valid, ex_ALUctrl, ex_ALUsrc, ex_ImmSrc, ex_RegWrite,
           ex_AddrMode, ex_ResultSrc, ex_WD3Src, ex_rd, PCsrc, flush, halted
  );

  modport slave (
    input  id_instr, id_valid, ex_eq, ex_lt, ex_ltu, resume,
    output id_ready, ex_valid, ex_ALUctrl, ex_ALUsrc, ex_ImmSrc, ex_RegWrite,
           ex_AddrMode, ex_ResultSrc, ex_WD3Src, ex_rd, PCsrc, flush, halted
  );
endinterface

// File: rtl/decode_pipe_ctrl.sv
// Pipelined RV32I control: decodes ID into a registered ID/EX control word, resolves
// branches in EX, and handles load-use interlock, taken-branch flush and halt.
//   state | meaning
//   RUN   | accepting ID instructions (id_ready=1)
//   STALL | load-use hazard cycle: ID held, bubble into EX
//   HALT  | ecall/ebreak/illegal seen; wait for resume
module decode_pipe_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int HAZARD_EN      = 1
) (
  input logic          clk,
  input logic          rst_n,
  decode_pipe_if.slave bus
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;

  typedef struct packed {
    logic                      valid;
    logic [3:0]                alu;
    logic                      src;
    logic [2:0]                imm;
    logic                      rw;
    logic [2:0]                am;
    logic                      res;
    logic                      wd;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [2:0]                f3;
    logic                      br;
    logic                      jal;
    logic                      jalr;
    logic                      load;
  } ex_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic sub_en,
                                        input logic sra_en);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = sra_en ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [DATA_WIDTH-1:0]     instr;
  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic                      f30;
  logic [REG_ADDR_WIDTH-1:0] rd, rs1, rs2;
  logic                      unused_instr;

  assign instr        = bus.id_instr;
  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign f30          = instr[30];
  assign rd           = instr[7 +: REG_ADDR_WIDTH];
  assign rs1          = instr[15 +: REG_ADDR_WIDTH];
  assign rs2          = instr[20 +: REG_ADDR_WIDTH];
  assign unused_instr = ^{instr[31], instr[29:25]};

  ex_t  dec;
  logic uses_rs1, uses_rs2, has_rd, halt_op;

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.f3    = funct3;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    has_rd    = 1'b1;
    halt_op   = 1'b0;
    case (opcode)
      OP_R: begin
        dec.alu  = alu_op(funct3, f30, f30);
        uses_rs2 = 1'b1;
      end
      OP_IMM: begin
        dec.alu = alu_op(funct3, 1'b0, f30);
        dec.src = 1'b1;
      end
      OP_LOAD: begin
        dec.src  = 1'b1;
        dec.res  = 1'b1;
        dec.load = 1'b1;
        case (funct3)
          3'b000:  dec.am = 3'b000;
          3'b001:  dec.am = 3'b001;
          3'b100:  dec.am = 3'b011;
          3'b101:  dec.am = 3'b100;
          default: dec.am = 3'b010;
        endcase
      end
      OP_STORE: begin
        dec.src  = 1'b1;
        dec.imm  = 3'b001;
        has_rd   = 1'b0;
        uses_rs2 = 1'b1;
        case (funct3)
          3'b000:  dec.am = 3'b101;
          3'b001:  dec.am = 3'b110;
          default: dec.am = 3'b111;
        endcase
      end
      OP_BRANCH: begin
        dec.alu  = ALU_SUB;
        dec.imm  = 3'b010;
        dec.br   = 1'b1;
        has_rd   = 1'b0;
        uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec.imm  = 3'b100;
        dec.wd   = 1'b1;
        dec.jal  = 1'b1;
        uses_rs1 = 1'b0;
      end
      OP_JALR: begin
        dec.src  = 1'b1;
        dec.wd   = 1'b1;
        dec.jalr = 1'b1;
      end
      OP_LUI: begin
        dec.alu  = ALU_LUI;
        dec.src  = 1'b1;
        dec.imm  = 3'b011;
        uses_rs1 = 1'b0;
      end
      OP_AUIPC: begin
        dec.src  = 1'b1;
        dec.imm  = 3'b011;
        uses_rs1 = 1'b0;
      end
      OP_SYSTEM: begin
        // Only ecall/ebreak halt; other SYSTEM encodings pass as a no-effect op.
        halt_op = (funct3 == 3'b000);
        has_rd  = 1'b0;
      end
      default: halt_op = 1'b1;
    endcase
    dec.rw = has_rd && (rd != '0);
    dec.rd = has_rd ? rd : '0;
  end

  ex_t        ex_q, ex_d;
  logic [1:0] state_q, state_d, state;
  logic       br_taken, flush, load_use, id_ready;
  logic [1:0] pcsrc;

  always_comb begin
    br_taken = 1'b0;
    case (ex_q.f3)
      3'b000:  br_taken = bus.ex_eq;
      3'b001:  br_taken = !bus.ex_eq;
      3'b100:  br_taken = bus.ex_lt;
      3'b101:  br_taken = !bus.ex_lt;
      3'b110:  br_taken = bus.ex_ltu;
      3'b111:  br_taken = !bus.ex_ltu;
      default: br_taken = 1'b0;
    endcase
    pcsrc = 2'b00;
    if (ex_q.valid) begin
      if (ex_q.jalr)                          pcsrc = 2'b10;
      else if (ex_q.jal || (ex_q.br && br_taken)) pcsrc = 2'b01;
    end
  end

  assign flush    = ex_q.valid && (pcsrc != 2'b00);
  assign load_use = (HAZARD_EN != 0) && ex_q.valid && ex_q.load && (ex_q.rd != '0) &&
                    ((uses_rs1 && (rs1 == ex_q.rd)) || (uses_rs2 && (rs2 == ex_q.rd)));

  // STALL is never held in state_q: the bubble it inserts clears the hazard next cycle.
  always_comb begin
    state = state_q;
    if (state_q == ST_RUN && !flush && bus.id_valid && load_use) state = ST_STALL;
    state_d  = state_q;
    ex_d     = '0;
    id_ready = 1'b0;
    case (state)
      ST_RUN: begin
        id_ready = 1'b1;
        if (!flush && bus.id_valid) begin
          if (halt_op) state_d = ST_HALT;
          else         ex_d    = dec;
        end
      end
      ST_STALL: state_d = ST_RUN;
      ST_HALT:  if (bus.resume) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
    end
  end

  assign bus.id_ready     = id_ready;
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_ALUctrl   = ex_q.alu;
  assign bus.ex_ALUsrc    = ex_q.src;
  assign bus.ex_ImmSrc    = ex_q.imm;
  assign bus.ex_RegWrite  = ex_q.rw;
  assign bus.ex_AddrMode  = ex_q.am;
  assign bus.ex_ResultSrc = ex_q.res;
  assign bus.ex_WD3Src    = ex_q.wd;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.PCsrc        = pcsrc;
  assign bus.flush        = flush;
  assign bus.halted       = (state_q == ST_HALT);

endmodule
